// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// The producer/consumer side takes the master modport; the pipeline takes the slave modport.
interface logic_unit_pipe_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] c;
  logic             OF;
  logic             CF;
  logic             SF;
  logic             ZF;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] op_count;

  modport master (
    output a, b, op, in_valid, out_ready,
    input  in_ready, c, OF, CF, SF, ZF, out_valid, op_count
  );

  modport slave (
    input  a, b, op, in_valid, out_ready,
    output in_ready, c, OF, CF, SF, ZF, out_valid, op_count
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage bitwise logic unit (AND/OR/XOR/NOR) with valid/ready flow control,
// result flags and a saturating count of delivered results.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  logic_unit_pipe_if.slave   bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             s1_valid;
  logic [WIDTH-1:0] s1_res;
  logic [WIDTH-1:0] func_c;
  logic             s1_load;
  logic             s2_load;

  logic [WIDTH-1:0] c_q;
  logic             sf_q;
  logic             zf_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] cnt_q;

  // S2 frees up when empty or draining; S1 frees up when empty or moving into S2.
  assign s2_load      = !out_valid_q || bus.out_ready;
  assign s1_load      = !s1_valid || s2_load;
  assign bus.in_ready = s1_load;

  always_comb begin
    func_c = '0;
    unique case (bus.op)
      2'b00:   func_c = bus.a & bus.b;
      2'b01:   func_c = bus.a | bus.b;
      2'b10:   func_c = bus.a ^ bus.b;
      default: func_c = ~(bus.a | bus.b);
    endcase
  end

  // Stage 1: bitwise result.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_res   <= '0;
    end else if (s1_load) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) s1_res <= func_c;
    end
  end

  // Stage 2: result, flags and out_valid; everything holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      c_q         <= '0;
      sf_q        <= 1'b0;
      zf_q        <= 1'b1;
    end else if (s2_load) begin
      out_valid_q <= s1_valid;
      c_q         <= s1_res;
      sf_q        <= s1_res[WIDTH-1];
      zf_q        <= (s1_res == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (out_valid_q && bus.out_ready && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.c         = c_q;
  assign bus.SF        = sf_q;
  assign bus.ZF        = zf_q;
  assign bus.CF        = 1'b0;
  assign bus.OF        = 1'b0;
  assign bus.out_valid = out_valid_q;
  assign bus.op_count  = cnt_q;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: a 32-bit instance checked by a scoreboard,
// plus a 4-bit-counter instance and an 8-bit instance for the corner cases.
module tb_logic_unit_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic_unit_pipe_if #(.WIDTH(32), .CNT_W(16)) m_if ();
  logic_unit_pipe_if #(.WIDTH(32), .CNT_W(4))  s_if ();
  logic_unit_pipe_if #(.WIDTH(8),  .CNT_W(16)) w_if ();

  logic_unit_pipe #(.WIDTH(32), .CNT_W(16)) dut_main (.clk(clk), .rst(rst), .bus(m_if.slave));
  logic_unit_pipe #(.WIDTH(32), .CNT_W(4))  dut_sat  (.clk(clk), .rst(rst), .bus(s_if.slave));
  logic_unit_pipe #(.WIDTH(8),  .CNT_W(16)) dut_w8   (.clk(clk), .rst(rst), .bus(w_if.slave));

  int checks = 0;
  int fails  = 0;

  logic [31:0] exp_q[$];
  logic [15:0] exp_cnt = '0;
  logic        mon_en  = 1'b0;
  logic        held_v  = 1'b0;
  logic [31:0] held_c  = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op);
    m_if.in_valid = v;
    m_if.a        = a;
    m_if.b        = b;
    m_if.op       = op;
  endtask

  // Scoreboard for the main instance: handshakes seen here complete at the next rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        exp_q.delete();
        exp_cnt = '0;
        held_v  = 1'b0;
      end else begin
        logic [31:0] e;
        chk("op_count", 64'(m_if.op_count), 64'(exp_cnt));
        if (held_v) chk("hold_c", 64'(m_if.c), 64'(held_c));
        if (m_if.out_valid && m_if.out_ready) begin
          chk("out_has_pending_in", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("c", 64'(m_if.c), 64'(e));
            chk("SF", 64'(m_if.SF), 64'(e[31]));
            chk("ZF", 64'(m_if.ZF), 64'(e == 32'h0));
            chk("CF", 64'(m_if.CF), 64'(0));
            chk("OF", 64'(m_if.OF), 64'(0));
          end
          if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end
        held_v = m_if.out_valid && !m_if.out_ready;
        held_c = m_if.c;
        if (m_if.in_valid && m_if.in_ready)
          exp_q.push_back(ref_fn(m_if.a, m_if.b, m_if.op));
      end
    end
  end

  initial begin
    drive(1'b0, '0, '0, 2'b00);
    m_if.out_ready = 1'b0;
    s_if.in_valid = 1'b0; s_if.a = '0; s_if.b = '0; s_if.op = 2'b00; s_if.out_ready = 1'b1;
    w_if.in_valid = 1'b0; w_if.a = '0; w_if.b = '0; w_if.op = 2'b00; w_if.out_ready = 1'b1;

    repeat (3) step();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(m_if.out_valid), 64'(0));
    chk("rst_c",         64'(m_if.c),         64'(0));
    chk("rst_ZF",        64'(m_if.ZF),        64'(1));
    chk("rst_SF",        64'(m_if.SF),        64'(0));
    chk("rst_cnt",       64'(m_if.op_count),  64'(0));
    chk("rst_in_ready",  64'(m_if.in_ready),  64'(1));
    mon_en = 1'b1;

    // Streaming: four ops back to back, results on four consecutive cycles.
    m_if.out_ready = 1'b1;
    drive(1'b1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 2'b00); step();
    chk("lat_not_yet", 64'(m_if.out_valid), 64'(0));
    drive(1'b1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 2'b01); step();
    chk("stream0_v", 64'(m_if.out_valid), 64'(1));
    chk("stream0_c", 64'(m_if.c), 64'h0000_0000);
    chk("stream0_zf", 64'(m_if.ZF), 64'(1));
    drive(1'b1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 2'b10); step();
    chk("stream1_c", 64'(m_if.c), 64'hFFFF_FFFF);
    chk("stream1_sf", 64'(m_if.SF), 64'(1));
    drive(1'b1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 2'b11); step();
    chk("stream2_c", 64'(m_if.c), 64'hFFFF_FFFF);
    drive(1'b0, '0, '0, 2'b00); step();
    chk("stream3_v", 64'(m_if.out_valid), 64'(1));
    chk("stream3_c", 64'(m_if.c), 64'h0000_0000);
    step();
    chk("stream_idle", 64'(m_if.out_valid), 64'(0));
    chk("stream_cnt", 64'(m_if.op_count), 64'(4));

    // Backpressure: two accepted, third stalls; junk offered during the stall is ignored.
    m_if.out_ready = 1'b0;
    drive(1'b1, 32'h0000_0001, 32'h0000_0002, 2'b01); step();
    chk("bp_ready1", 64'(m_if.in_ready), 64'(1));
    drive(1'b1, 32'h0000_0005, 32'h0000_0003, 2'b10); step();
    chk("bp_full_ready", 64'(m_if.in_ready), 64'(0));
    chk("bp_c", 64'(m_if.c), 64'h0000_0003);
    drive(1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 2'b01); step();
    chk("bp_still_full", 64'(m_if.in_ready), 64'(0));
    chk("bp_c_held", 64'(m_if.c), 64'h0000_0003);
    // Simultaneous drain and fill while full.
    drive(1'b1, 32'hFFFF_0000, 32'h0000_FFFF, 2'b00);
    m_if.out_ready = 1'b1;
    #1;
    chk("sim_in_ready", 64'(m_if.in_ready), 64'(1));
    step();
    drive(1'b0, '0, '0, 2'b00);
    chk("sim_v", 64'(m_if.out_valid), 64'(1));
    chk("sim_c", 64'(m_if.c), 64'h0000_0006);
    step();
    chk("sim_c2", 64'(m_if.c), 64'h0000_0000);
    chk("sim_v2", 64'(m_if.out_valid), 64'(1));
    step();
    chk("bp_drained", 64'(m_if.out_valid), 64'(0));
    chk("bp_cnt", 64'(m_if.op_count), 64'(7));

    // Reset with two operations in flight.
    m_if.out_ready = 1'b0;
    drive(1'b1, 32'h8000_0000, 32'h0000_0000, 2'b01); step();
    drive(1'b1, 32'h0000_00F0, 32'h0000_0011, 2'b10); step();
    chk("mr_loaded", 64'(m_if.c), 64'h8000_0000);
    drive(1'b0, '0, '0, 2'b00);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_v", 64'(m_if.out_valid), 64'(0));
    chk("mr_c", 64'(m_if.c), 64'(0));
    chk("mr_zf", 64'(m_if.ZF), 64'(1));
    chk("mr_sf", 64'(m_if.SF), 64'(0));
    chk("mr_cnt", 64'(m_if.op_count), 64'(0));
    chk("mr_in_ready", 64'(m_if.in_ready), 64'(1));
    m_if.out_ready = 1'b1;
    repeat (3) step();
    chk("mr_no_ghost", 64'(m_if.out_valid), 64'(0));
    chk("mr_cnt_after", 64'(m_if.op_count), 64'(0));
    chk("drain", 64'(exp_q.size()), 64'(0));

    // Saturation on a 4-bit counter.
    s_if.in_valid = 1'b1;
    s_if.a = 32'h1234_5678; s_if.b = 32'h0F0F_0F0F; s_if.op = 2'b10;
    repeat (20) step();
    s_if.in_valid = 1'b0;
    repeat (3) step();
    chk("sat_cnt", 64'(s_if.op_count), 64'(15));
    chk("sat_c", 64'(s_if.c), 64'h1D3B_5977);

    // 8-bit NOR of zeros.
    w_if.in_valid = 1'b1; w_if.a = 8'h00; w_if.b = 8'h00; w_if.op = 2'b11;
    step();
    w_if.in_valid = 1'b0;
    step();
    chk("w8_v", 64'(w_if.out_valid), 64'(1));
    chk("w8_c", 64'(w_if.c), 64'h0000_00FF);
    chk("w8_sf", 64'(w_if.SF), 64'(1));
    chk("w8_zf", 64'(w_if.ZF), 64'(0));
    chk("w8_cf", 64'(w_if.CF), 64'(0));
    chk("w8_of", 64'(w_if.OF), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
